// File: rtl/d8_pkg.sv
// Shared constants for the d8 core: datapath widths, register count and the
// default set of opcodes that write back to the register file.
package d8_pkg;

    localparam int unsigned D8_OP_W   = 8;
    localparam int unsigned D8_DATA_W = 8;
    localparam int unsigned D8_NREG   = 8;

    // Bit k set => opcode k produces a register write-back.
    localparam logic [255:0] D8_WR_MASK = 256'hFE;

    localparam logic [7:0] D8_OP_WR1 = 8'h01;
    localparam logic [7:0] D8_OP_WR2 = 8'h02;
    localparam logic [7:0] D8_OP_WR3 = 8'h03;
    localparam logic [7:0] D8_OP_WR4 = 8'h04;
    localparam logic [7:0] D8_OP_WR5 = 8'h05;
    localparam logic [7:0] D8_OP_WR6 = 8'h06;
    localparam logic [7:0] D8_OP_WR7 = 8'h07;

endpackage

// File: rtl/d8_reg_scoreboard_if.sv
// Issue, write-back and register-file port bundle between decode/execute and
// the d8 register scoreboard.
interface d8_reg_scoreboard_if
    import d8_pkg::*;
#(
    parameter int unsigned OP_W   = D8_OP_W,
    parameter int unsigned DATA_W = D8_DATA_W,
    parameter int unsigned NREG   = D8_NREG,
    parameter int unsigned AW     = $clog2(NREG)
);

    logic              iss_valid;
    logic [OP_W-1:0]   iss_op;
    logic [AW-1:0]     iss_rd;
    logic [AW-1:0]     iss_rs;
    logic              iss_rs_en;
    logic              iss_ready;
    logic              iss_w;

    logic              wb_valid;
    logic [AW-1:0]     wb_rd;
    logic [DATA_W-1:0] wb_data;

    logic              flush;

    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [NREG-1:0]   pending;
    logic              err_spurious;

    modport master (
        output iss_valid, iss_op, iss_rd, iss_rs, iss_rs_en,
        output wb_valid, wb_rd, wb_data, flush,
        input  iss_ready, iss_w, rf_we, rf_waddr, rf_wdata, pending, err_spurious
    );

    modport slave (
        input  iss_valid, iss_op, iss_rd, iss_rs, iss_rs_en,
        input  wb_valid, wb_rd, wb_data, flush,
        output iss_ready, iss_w, rf_we, rf_waddr, rf_wdata, pending, err_spurious
    );

endinterface

// File: rtl/d8_op_wr_decode.sv
// Combinational lookup: does this opcode write a register? Opcodes beyond the
// 256-entry mask (only reachable when OP_W > 8) never write.
module d8_op_wr_decode
    import d8_pkg::*;
#(
    parameter int unsigned  OP_W    = D8_OP_W,
    parameter logic [255:0] WR_MASK = D8_WR_MASK
) (
    input  logic [OP_W-1:0] op,
    output logic            wr
);

    localparam int unsigned IDX_W = (OP_W < 8) ? OP_W : 8;

    logic op_high;

    generate
        if (OP_W > 8) begin : g_wide
            assign op_high = |op[OP_W-1:8];
        end else begin : g_narrow
            assign op_high = 1'b0;
        end
    endgenerate

    always_comb begin
        wr = 1'b0;
        if (!op_high) begin
            wr = WR_MASK[op[IDX_W-1:0]];
        end
    end

endmodule

// File: rtl/d8_reg_scoreboard.sv
// Register write-back controller: tracks outstanding register writes, stalls
// issue on RAW/WAW hazards and retires write-backs to a registered RF port.
module d8_reg_scoreboard
    import d8_pkg::*;
#(
    parameter int unsigned  OP_W    = D8_OP_W,
    parameter int unsigned  DATA_W  = D8_DATA_W,
    parameter int unsigned  NREG    = D8_NREG,
    parameter int unsigned  AW      = $clog2(NREG),
    parameter logic [255:0] WR_MASK = D8_WR_MASK
) (
    input logic                sys_clk,
    input logic                sys_rst_n,
    d8_reg_scoreboard_if.slave bus
);

    logic [NREG-1:0]   pending_q, pending_d;
    logic              rf_we_q, rf_we_d;
    logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              err_q, err_d;

    logic iss_w;
    logic raw_hazard;
    logic waw_hazard;
    logic iss_ready;
    logic iss_accept;

    d8_op_wr_decode #(
        .OP_W    (OP_W),
        .WR_MASK (WR_MASK)
    ) u_op_wr_decode (
        .op (bus.iss_op),
        .wr (iss_w)
    );

    // Hazards look only at registered state: a write-back landing this cycle
    // does not release a stalled consumer until the next cycle.
    always_comb begin
        raw_hazard = bus.iss_rs_en && pending_q[bus.iss_rs];
        waw_hazard = iss_w && pending_q[bus.iss_rd];
        iss_ready  = !bus.flush && !raw_hazard && !waw_hazard;
        iss_accept = bus.iss_valid && iss_ready;
    end

    // Order matters: clear, then flush, then set, so a new producer wins over
    // a same-cycle retirement. Accept already excludes flush cycles.
    always_comb begin
        pending_d = pending_q;
        if (bus.wb_valid) begin
            pending_d[bus.wb_rd] = 1'b0;
        end
        if (bus.flush) begin
            pending_d = '0;
        end
        if (iss_accept && iss_w) begin
            pending_d[bus.iss_rd] = 1'b1;
        end
    end

    always_comb begin
        rf_we_d    = bus.wb_valid;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_d      = err_q;
        if (bus.wb_valid) begin
            rf_waddr_d = bus.wb_rd;
            rf_wdata_d = bus.wb_data;
            if (!bus.flush && !pending_q[bus.wb_rd]) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pending_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    assign bus.iss_w        = iss_w;
    assign bus.iss_ready    = iss_ready;
    assign bus.pending      = pending_q;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_d8_reg_scoreboard.sv
// Bench for d8_reg_scoreboard: directed vector table, async-reset sequence and
// a randomized run against a set-based reference model.
module tb_d8_reg_scoreboard;

    logic clk;
    logic rst_n;

    int checks;
    int failures;

    d8_reg_scoreboard_if bus ();

    d8_reg_scoreboard dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         valid;
        logic [7:0] op;
        logic [2:0] rd;
        logic [2:0] rs;
        bit         rs_en;
        bit         wb;
        logic [2:0] wb_rd;
        logic [7:0] wb_data;
        bit         fl;
        bit         e_ready;
        logic [7:0] e_pend;
        bit         e_we;
        logic [2:0] e_waddr;
        logic [7:0] e_wdata;
        bit         e_err;
    } vec_t;

    vec_t vecs[10];

    // Reference model: the set of registers with an outstanding producer.
    bit         m_out[int];
    bit         m_err;
    bit         m_we;
    logic [2:0] m_waddr;
    logic [7:0] m_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit valid, input logic [7:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input bit rs_en, input bit wb,
                         input logic [2:0] wb_rd, input logic [7:0] wb_data, input bit fl);
        bus.iss_valid = valid;
        bus.iss_op    = op;
        bus.iss_rd    = rd;
        bus.iss_rs    = rs;
        bus.iss_rs_en = rs_en;
        bus.wb_valid  = wb;
        bus.wb_rd     = wb_rd;
        bus.wb_data   = wb_data;
        bus.flush     = fl;
    endtask

    function automatic logic [7:0] model_bitmap();
        logic [7:0] b = '0;
        for (int i = 0; i < 8; i++) if (m_out.exists(i)) b[i] = 1'b1;
        return b;
    endfunction

    function automatic bit op_writes(input logic [7:0] op);
        return (op >= 8'd1) && (op <= 8'd7);
    endfunction

    task automatic model_reset();
        m_out.delete();
        m_err   = 1'b0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    task automatic do_reset();
        drive(0, 8'h00, 3'd0, 3'd0, 0, 0, 3'd0, 8'h00, 0);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_pending", {24'd0, bus.pending}, 32'h0);
        check("rst_rf_we", {31'd0, bus.rf_we}, 32'h0);
        check("rst_err", {31'd0, bus.err_spurious}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input bit valid, input logic [7:0] op, input logic [2:0] rd,
                              input logic [2:0] rs, input bit rs_en, input bit wb,
                              input logic [2:0] wb_rd, input logic [7:0] wb_data,
                              input bit fl, output bit ready);
        bit w;
        bit nxt[int];
        w     = op_writes(op);
        ready = !fl && !(rs_en && m_out.exists(int'(rs))) && !(w && m_out.exists(int'(rd)));
        nxt   = m_out;
        if (wb) begin
            if (!fl && !m_out.exists(int'(wb_rd))) m_err = 1'b1;
            nxt.delete(int'(wb_rd));
            m_waddr = wb_rd;
            m_wdata = wb_data;
        end
        m_we = wb;
        if (fl) nxt.delete();
        if (valid && ready && w) nxt[int'(rd)] = 1'b1;
        m_out = nxt;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(0, 8'h00, 3'd0, 3'd0, 0, 0, 3'd0, 8'h00, 0);

        //         rst v  op     rd rs en wb wbrd wbdata fl  rdy pend  we addr data  err
        vecs[0] = '{0, 1, 8'h03, 2, 0, 0, 0, 0, 8'h00, 0,  1, 8'h04, 0, 0, 8'h00, 0};
        vecs[1] = '{0, 1, 8'h00, 0, 2, 1, 1, 2, 8'h5A, 0,  0, 8'h00, 1, 2, 8'h5A, 0};
        vecs[2] = '{0, 1, 8'h00, 0, 2, 1, 0, 0, 8'h00, 0,  1, 8'h00, 0, 2, 8'h5A, 0};
        vecs[3] = '{0, 1, 8'h07, 5, 0, 0, 0, 0, 8'h00, 0,  1, 8'h20, 0, 2, 8'h5A, 0};
        vecs[4] = '{0, 1, 8'h07, 5, 0, 0, 0, 0, 8'h00, 0,  0, 8'h20, 0, 2, 8'h5A, 0};
        vecs[5] = '{0, 1, 8'h08, 5, 0, 0, 0, 0, 8'h00, 0,  1, 8'h20, 0, 2, 8'h5A, 0};
        vecs[6] = '{0, 1, 8'h01, 2, 0, 0, 0, 0, 8'h00, 0,  1, 8'h24, 0, 2, 8'h5A, 0};
        vecs[7] = '{0, 1, 8'h01, 3, 0, 0, 1, 5, 8'h44, 1,  0, 8'h00, 1, 5, 8'h44, 0};
        vecs[8] = '{0, 0, 8'h00, 0, 0, 0, 1, 5, 8'h33, 0,  1, 8'h00, 1, 5, 8'h33, 1};
        vecs[9] = '{1, 1, 8'h01, 3, 0, 0, 1, 3, 8'h11, 0,  1, 8'h08, 1, 3, 8'h11, 1};

        do_reset();
        check("reset_ready", {31'd0, bus.iss_ready}, 32'h1);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].valid, vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].rs_en,
                  vecs[i].wb, vecs[i].wb_rd, vecs[i].wb_data, vecs[i].fl);
            #1;
            check($sformatf("v%0d_ready", i), {31'd0, bus.iss_ready}, {31'd0, vecs[i].e_ready});
            check($sformatf("v%0d_iss_w", i), {31'd0, bus.iss_w},
                  {31'd0, op_writes(vecs[i].op)});
            @(posedge clk);
            #1;
            drive(0, 8'h00, 3'd0, 3'd0, 0, 0, 3'd0, 8'h00, 0);
            check($sformatf("v%0d_pending", i), {24'd0, bus.pending}, {24'd0, vecs[i].e_pend});
            check($sformatf("v%0d_rf_we", i), {31'd0, bus.rf_we}, {31'd0, vecs[i].e_we});
            check($sformatf("v%0d_waddr", i), {29'd0, bus.rf_waddr}, {29'd0, vecs[i].e_waddr});
            check($sformatf("v%0d_wdata", i), {24'd0, bus.rf_wdata}, {24'd0, vecs[i].e_wdata});
            check($sformatf("v%0d_err", i), {31'd0, bus.err_spurious}, {31'd0, vecs[i].e_err});
        end

        // Fill every register, then reset mid-cycle: outputs must clear at once.
        do_reset();
        for (int r = 0; r < 7; r++) begin
            drive(1, 8'h02, r[2:0], 3'd0, 0, 0, 3'd0, 8'h00, 0);
            @(posedge clk);
            #1;
        end
        drive(1, 8'h05, 3'd7, 3'd0, 0, 1, 3'd7, 8'hC3, 0);
        @(posedge clk);
        #1;
        drive(0, 8'h00, 3'd0, 3'd0, 0, 0, 3'd0, 8'h00, 0);
        check("full_pending", {24'd0, bus.pending}, 32'hFF);
        check("full_rf_we", {31'd0, bus.rf_we}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pending", {24'd0, bus.pending}, 32'h0);
        check("async_rf_we", {31'd0, bus.rf_we}, 32'h0);
        check("async_waddr", {29'd0, bus.rf_waddr}, 32'h0);
        check("async_wdata", {24'd0, bus.rf_wdata}, 32'h0);
        check("async_err", {31'd0, bus.err_spurious}, 32'h0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit         valid, rs_en, wb, fl, ready;
            logic [7:0] op, wb_data;
            logic [2:0] rd, rs, wb_rd;
            int         keys[$];
            if (c % 150 == 149) do_reset();
            valid   = ($urandom_range(0, 3) != 0);
            op      = 8'($urandom_range(0, 15));
            rd      = 3'($urandom_range(0, 7));
            rs      = 3'($urandom_range(0, 7));
            rs_en   = $urandom_range(0, 1) == 1;
            wb      = $urandom_range(0, 1) == 1;
            wb_data = 8'($urandom);
            fl      = ($urandom_range(0, 19) == 0);
            keys.delete();
            foreach (m_out[k]) keys.push_back(k);
            if (keys.size() > 0 && $urandom_range(0, 7) != 0)
                wb_rd = 3'(keys[$urandom_range(0, keys.size() - 1)]);
            else
                wb_rd = 3'($urandom_range(0, 7));
            drive(valid, op, rd, rs, rs_en, wb, wb_rd, wb_data, fl);
            model_step(valid, op, rd, rs, rs_en, wb, wb_rd, wb_data, fl, ready);
            #1;
            check("rnd_ready", {31'd0, bus.iss_ready}, {31'd0, ready});
            check("rnd_iss_w", {31'd0, bus.iss_w}, {31'd0, op_writes(op)});
            @(posedge clk);
            #1;
            check("rnd_pending", {24'd0, bus.pending}, {24'd0, model_bitmap()});
            check("rnd_rf_we", {31'd0, bus.rf_we}, {31'd0, m_we});
            check("rnd_waddr", {29'd0, bus.rf_waddr}, {29'd0, m_waddr});
            check("rnd_wdata", {24'd0, bus.rf_wdata}, {24'd0, m_wdata});
            check("rnd_err", {31'd0, bus.err_spurious}, {31'd0, m_err});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/d8_reg_scoreboard.md
Name: d8_reg_scoreboard

Overview:
- Parametrised register write-back controller and scoreboard for the d8 core.
- Decodes whether an issued opcode writes the register file, using a parametrised opcode mask (the d8 default is opcodes 0x01–0x07).
- Tracks per-register pending writes, stalls issue on RAW/WAW hazards, and retires variable-latency write-backs into a registered register-file write port.
- Sits between the decode/issue stage and the register file.

Parameters:
- OP_W, 8, opcode width.
- DATA_W, 8, register data width.
- NREG, 8, number of architectural registers (power of two, ≥2).
- AW, $clog2(NREG), register address width.
- WR_MASK, 256'hFE, bit k set ⇒ opcode k writes a register (default: 0x01–0x07).

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  issue request.
- iss_op  in  OP_W  opcode of issuing instruction.
- iss_rd  in  AW  destination register.
- iss_rs  in  AW  source register.
- iss_rs_en  in  1  instruction reads iss_rs.
- iss_ready  out  1  issue may be accepted this cycle.
- iss_w  out  1  combinational decode: WR_MASK[iss_op].
- wb_valid  in  1  execution unit result valid.
- wb_rd  in  AW  result destination.
- wb_data  in  DATA_W  result value.
- flush  in  1  pipeline flush, drop all pending writes.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  AW  register-file write address.
- rf_wdata  out  DATA_W  register-file write data.
- pending  out  NREG  scoreboard bitmap.
- err_spurious  out  1  sticky: write-back to non-pending register.

Behaviour:
- Reset (async, sys_rst_n low): pending=0, rf_we=0, rf_waddr=0, rf_wdata=0, err_spurious=0. Reset mid-operation discards all in-flight pending state; write-backs arriving after reset are flagged spurious.
- iss_w = WR_MASK[iss_op] (opcodes ≥256 only when OP_W>8: treated as non-writing).
- iss_ready = !flush && !(iss_rs_en && pending[iss_rs]) && !(iss_w && pending[iss_rd]).
  - Computed from registered pending only; no same-cycle write-back bypass.
- Issue accept = iss_valid && iss_ready. If accepted and iss_w, pending[iss_rd] is set next edge.
- Write-back: when wb_valid, the next edge gives rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data, and clears pending[wb_rd]. Latency is exactly 1 cycle. rf_we=0 in cycles without wb_valid; rf_waddr/rf_wdata hold their last values.
- Spurious write-back: wb_valid with pending[wb_rd]=0 still writes the register file, and err_spurious sets and stays set until reset.
- Simultaneous set and clear of the same register in one cycle: set wins (new producer outstanding).
  - Cannot arise via WAW stall unless the write-back and issue target a register that was not pending; the rule still applies.
- flush: next edge clears all pending bits, except a set from the same cycle is suppressed because issue is blocked. A write-back in the flush cycle is still written to the register file and not flagged spurious. Later write-backs to flushed registers are flagged spurious.
- Non-writing opcodes (e.g. 0x00, 0x08) never touch pending.
- No internal FSM beyond the NREG-bit scoreboard and the output register.

Decomposition:
- Package d8_pkg: OP_W, DATA_W, NREG constants; the default write-opcode mask constant D8_WR_MASK=256'hFE; opcode localparams 0x01–0x07.
- Sub-module d8_op_wr_decode: parametrised combinational WR_MASK lookup producing iss_w, reused by decode.

Test Plan:
- Reset → pending=0x00, rf_we=0, err_spurious=0; issue op=0x03 rd=2 with iss_valid → iss_ready=1, pending=0x04 next cycle.
- RAW: pending=0x04, issue op=0x00 rs=2 rs_en=1 → iss_ready=0; wb_valid rd=2 data=0x5A → next cycle rf_we=1, rf_waddr=2, rf_wdata=0x5A, pending=0x00, iss_ready=1.
- WAW: pending[5]=1, issue op=0x07 rd=5 → stalled; issue op=0x08 rd=5 → accepted, pending unchanged.
- Same cycle: pending=0, issue op=0x01 rd=3 plus wb_valid rd=3 → err_spurious=1, rf_we=1, pending=0x08 (set wins).
- Flush: pending=0x24, flush=1 with iss_valid → iss_ready=0, pending=0x00 next; later wb rd=5 → rf written, err_spurious=1.
- Async reset asserted mid-cycle with pending=0xFF, rf_we=1 → all outputs zero immediately, without waiting for a clock edge.
